// File: rtl/serial_compare_ctrl_if.sv
// Request-side bundle for serial_compare_ctrl.
//
// Handshake: start is a request level sampled on a rising clk edge only
// while busy=0 (IDLE or DONE); A and B are captured on that same edge.
// busy stays high for the whole scan. done is a one-cycle pulse marking the
// cycle in which the three result flags first carry the new result. The
// flags then hold until the next done or reset.
interface serial_compare_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic             A_GREATER_B;
  logic             A_LESS_B;
  logic             A_EQUAL_B;

  // Requesting datapath side
  modport master (
    output start, A, B,
    input  busy, done, A_GREATER_B, A_LESS_B, A_EQUAL_B
  );

  // Compare sequencer side
  modport slave (
    input  start, A, B,
    output busy, done, A_GREATER_B, A_LESS_B, A_EQUAL_B
  );
endinterface

// File: rtl/serial_compare_ctrl.sv
// Bit-serial magnitude compare sequencer.
// Walks both latched operands MSB first through one shared 1-bit compare cell.
// The first differing bit decides the result. With SIGNED=1 the sense of the
// MSB is swapped, because a set sign bit means a smaller two's-complement value.
// Optional feature macro: EARLY_EXIT_EN. When it is defined, the scan stops on
// the first differing bit. When it is not defined, the scan always takes WIDTH
// cycles. The result is the same in both builds.
// dbg_state exposes the FSM state. dbg_cell_err flags a non one-hot cell
// response during SCAN.
module serial_compare_ctrl #(
  parameter int WIDTH  = 4,
  parameter bit SIGNED = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  serial_compare_ctrl_if.slave bus,
  output logic                 cmp_a,
  output logic                 cmp_b,
  input  logic                 cmp_gt,
  input  logic                 cmp_eq,
  input  logic                 cmp_lt,
  output logic [1:0]           dbg_state,
  output logic                 dbg_cell_err
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] IDX_MSB = IW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  logic [IW-1:0]    idx;
  logic             diff_found;  // an earlier (more significant) bit differed
  logic             diff_gt;     // direction of that first difference
  logic             busy_r;
  logic             done_r;
  logic             gt_r;
  logic             lt_r;
  logic             eq_r;

  logic             bit_gt;
  logic             bit_lt;
  logic             msb_inv;
  logic             a_gt;
  logic             a_lt;
  logic             found_nx;
  logic             gt_nx;
  logic             scan_last;

  // Bits to the shared cell. Both are held low outside SCAN.
  assign cmp_a = (state == S_SCAN) ? a_reg[idx] : 1'b0;
  assign cmp_b = (state == S_SCAN) ? b_reg[idx] : 1'b0;

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.A_GREATER_B = gt_r;
  assign bus.A_LESS_B    = lt_r;
  assign bus.A_EQUAL_B   = eq_r;
  assign dbg_state       = state;

  // During SCAN the cell must report exactly one of gt/eq/lt.
  assign dbg_cell_err = (state == S_SCAN) && ($countones({cmp_gt, cmp_eq, cmp_lt}) != 1);

  // Decode the cell response and apply the sign swap at the MSB.
  always_comb begin
    bit_gt   = cmp_gt;
    bit_lt   = ~cmp_gt & cmp_lt;
    msb_inv  = SIGNED && (idx == IDX_MSB);
    a_gt     = msb_inv ? bit_lt : bit_gt;
    a_lt     = msb_inv ? bit_gt : bit_lt;
    found_nx = diff_found | a_gt | a_lt;
    gt_nx    = diff_found ? diff_gt : a_gt;
`ifdef EARLY_EXIT_EN
    scan_last = (idx == '0) | a_gt | a_lt;
`else
    scan_last = (idx == '0);
`endif
  end

  // Sequencer FSM with registered status and result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      idx        <= IDX_MSB;
      diff_found <= 1'b0;
      diff_gt    <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      gt_r       <= 1'b0;
      lt_r       <= 1'b0;
      eq_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state      <= S_SCAN;
            a_reg      <= bus.A;
            b_reg      <= bus.B;
            idx        <= IDX_MSB;
            diff_found <= 1'b0;
            diff_gt    <= 1'b0;
            busy_r     <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
        S_SCAN: begin
          if (scan_last) begin
            state  <= S_DONE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
            gt_r   <= found_nx & gt_nx;
            lt_r   <= found_nx & ~gt_nx;
            eq_r   <= ~found_nx;
          end else begin
            idx        <= idx - 1'b1;
            diff_found <= found_nx;
            diff_gt    <= gt_nx;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_compare_ctrl.sv
// Bench for serial_compare_ctrl. It drives two instances with the same
// stimulus: one with SIGNED=1 and one with SIGNED=0. Each instance has its own
// 1-bit compare cell. Expected results come from integer magnitude compares.
// Expected scan lengths come from the position of the highest differing bit.
module tb_serial_compare_ctrl;

  localparam int W = 4;
`ifdef EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_compare_ctrl_if #(.WIDTH(W)) bus_s ();
  serial_compare_ctrl_if #(.WIDTH(W)) bus_u ();

  logic cmp_a_s, cmp_b_s, cmp_gt_s, cmp_eq_s, cmp_lt_s, cell_err_s;
  logic cmp_a_u, cmp_b_u, cmp_gt_u, cmp_eq_u, cmp_lt_u, cell_err_u;
  logic [1:0] dbg_state_s, dbg_state_u;

  // Shared 1-bit compare cells
  assign cmp_gt_s = cmp_a_s & ~cmp_b_s;
  assign cmp_eq_s = ~(cmp_a_s ^ cmp_b_s);
  assign cmp_lt_s = ~cmp_a_s & cmp_b_s;
  assign cmp_gt_u = cmp_a_u & ~cmp_b_u;
  assign cmp_eq_u = ~(cmp_a_u ^ cmp_b_u);
  assign cmp_lt_u = ~cmp_a_u & cmp_b_u;

  serial_compare_ctrl #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(bus_s),
    .cmp_a(cmp_a_s), .cmp_b(cmp_b_s),
    .cmp_gt(cmp_gt_s), .cmp_eq(cmp_eq_s), .cmp_lt(cmp_lt_s),
    .dbg_state(dbg_state_s), .dbg_cell_err(cell_err_s)
  );

  serial_compare_ctrl #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .bus(bus_u),
    .cmp_a(cmp_a_u), .cmp_b(cmp_b_u),
    .cmp_gt(cmp_gt_u), .cmp_eq(cmp_eq_u), .cmp_lt(cmp_lt_u),
    .dbg_state(dbg_state_u), .dbg_cell_err(cell_err_u)
  );

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;

  // Per-cycle observations, [dut][cycle]. Dut 0 is signed; dut 1 is unsigned.
  logic       busy_o  [0:1][0:15];
  logic       done_o  [0:1][0:15];
  logic [2:0] flags_o [0:1][0:15];  // {gt, lt, eq}
  logic [1:0] cmpab_o [0:1][0:15];
  logic       cerr_o  [0:1][0:15];

  int         inj_cyc = 0;
  logic [W-1:0] inj_a = '0;
  logic [W-1:0] inj_b = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int ref_order(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    int va;
    int vb;
    va = int'(a);
    vb = int'(b);
    if (sgn && va >= (1 << (W - 1))) va -= (1 << W);
    if (sgn && vb >= (1 << (W - 1))) vb -= (1 << W);
    return (va > vb) ? 1 : ((va < vb) ? -1 : 0);
  endfunction

  function automatic logic [2:0] ref_flags(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
    int r;
    r = ref_order(a, b, sgn);
    return (r > 0) ? 3'b100 : ((r < 0) ? 3'b010 : 3'b001);
  endfunction

  function automatic int ref_scan_len(input logic [W-1:0] a, input logic [W-1:0] b);
    if (!EARLY) return W;
    for (int i = W - 1; i >= 0; i--)
      if (a[i] != b[i]) return W - i;
    return W;
  endfunction

  function automatic int first_done(input int k);
    for (int c = 1; c < 16; c++)
      if (done_o[k][c] === 1'b1) return c;
    return 0;
  endfunction

  function automatic int count_done(input int k);
    int n;
    n = 0;
    for (int c = 1; c < 16; c++)
      if (done_o[k][c] === 1'b1) n++;
    return n;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    bus_s.start = s; bus_s.A = a; bus_s.B = b;
    bus_u.start = s; bus_u.A = a; bus_u.B = b;
  endtask

  // Present a start, then return just after the edge that samples it (edge 0).
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    drive(1'b1, a, b);
    @(posedge clk);
  endtask

  // Record cycles 1..n. Start is raised again only in cycle inj_cyc.
  // Otherwise the operand lines carry junk, which the DUT must ignore.
  task automatic watch(input int n);
    for (int c = 0; c < 16; c++)
      for (int k = 0; k < 2; k++) begin
        busy_o[k][c] = 1'b0; done_o[k][c] = 1'b0; flags_o[k][c] = 3'b000;
        cmpab_o[k][c] = 2'b00; cerr_o[k][c] = 1'b0;
      end
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c == inj_cyc) drive(1'b1, inj_a, inj_b);
      else drive(1'b0, W'($urandom), W'($urandom));
      busy_o[0][c]  = bus_s.busy;
      done_o[0][c]  = bus_s.done;
      flags_o[0][c] = {bus_s.A_GREATER_B, bus_s.A_LESS_B, bus_s.A_EQUAL_B};
      cmpab_o[0][c] = {cmp_a_s, cmp_b_s};
      cerr_o[0][c]  = cell_err_s;
      busy_o[1][c]  = bus_u.busy;
      done_o[1][c]  = bus_u.done;
      flags_o[1][c] = {bus_u.A_GREATER_B, bus_u.A_LESS_B, bus_u.A_EQUAL_B};
      cmpab_o[1][c] = {cmp_a_u, cmp_b_u};
      cerr_o[1][c]  = cell_err_u;
    end
  endtask

  // Check one single-operation window of W+3 cycles against the model.
  task automatic check_run(input int k, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int n;
    logic [2:0] ef;
    string t;
    n  = ref_scan_len(a, b);
    ef = ref_flags(a, b, k == 0);
    t  = $sformatf("%s dut%0d a=%0h b=%0h", tag, k, a, b);
    check({t, " busy@1"}, busy_o[k][1], 1'b1);
    check({t, " busy@N"}, busy_o[k][n], 1'b1);
    check({t, " busy@N+1"}, busy_o[k][n+1], 1'b0);
    check({t, " done_cycle"}, first_done(k), n + 1);
    check({t, " done_count"}, count_done(k), 1);
    check({t, " flags@done"}, flags_o[k][n+1], ef);
    check({t, " flags_hold"}, flags_o[k][W+3], ef);
    check({t, " cmp_idle"}, cmpab_o[k][n+2], 2'b00);
    check({t, " cell_err"}, cerr_o[k][1] | cerr_o[k][n], 1'b0);
  endtask

  // Run one compare on both DUTs and check both.
  task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    inj_cyc = 0;
    launch(a, b);
    watch(W + 3);
    check_run(0, a, b, tag);
    check_run(1, a, b, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    int n_s;
    drive(1'b0, '0, '0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst busy_s", bus_s.busy, 1'b0);
    check("rst done_s", bus_s.done, 1'b0);
    check("rst flags_s", {bus_s.A_GREATER_B, bus_s.A_LESS_B, bus_s.A_EQUAL_B}, 3'b000);
    check("rst cmp_s", {cmp_a_s, cmp_b_s}, 2'b00);
    check("rst busy_u", bus_u.busy, 1'b0);
    check("rst flags_u", {bus_u.A_GREATER_B, bus_u.A_LESS_B, bus_u.A_EQUAL_B}, 3'b000);
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands: full scan, EQUAL result
    run_one(4'b0011, 4'b0011, "t1");
    check("t1 literal eq", flags_o[0][5], 3'b001);
    check("t1 literal done", first_done(0), 5);

    // -1 vs +1 signed: LESS; the MSB differs
    run_one(4'b1111, 4'b0001, "t2");
    check("t2 literal less", flags_o[0][first_done(0)], 3'b010);
    n_s = EARLY ? 2 : 5;
    check("t2 literal done", first_done(0), n_s);

    // Difference only at bit 0: full latency in both builds
    run_one(4'b0101, 4'b0100, "t3");
    check("t3 literal done", first_done(0), 5);

    // Unsigned 8 vs 7: GREATER, with no MSB swap
    run_one(4'b1000, 4'b0111, "t4");
    check("t4 literal gt", flags_o[1][first_done(1)], 3'b100);
    check("t4 signed less", flags_o[0][first_done(0)], 3'b010);

    // A start during SCAN is ignored
    inj_cyc = 2; inj_a = 4'd9; inj_b = 4'd1;
    launch(4'd3, 4'd3);
    watch(W + 4);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t5 ign dut%0d done_cycle", k), first_done(k), 5);
      check($sformatf("t5 ign dut%0d done_count", k), count_done(k), 1);
      check($sformatf("t5 ign dut%0d flags", k), flags_o[k][5], 3'b001);
    end

    // Reset in the middle of a scan
    inj_cyc = 0;
    launch(4'd5, 4'd2);
    watch(3);
    #1 rst_n = 1'b0;
    #1;
    check("t5 rst busy_s", bus_s.busy, 1'b0);
    check("t5 rst done_s", bus_s.done, 1'b0);
    check("t5 rst flags_s", {bus_s.A_GREATER_B, bus_s.A_LESS_B, bus_s.A_EQUAL_B}, 3'b000);
    check("t5 rst cmp_s", {cmp_a_s, cmp_b_s}, 2'b00);
    check("t5 rst busy_u", bus_u.busy, 1'b0);
    check("t5 rst flags_u", {bus_u.A_GREATER_B, bus_u.A_LESS_B, bus_u.A_EQUAL_B}, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    watch(6);
    check("t5 rst no done_s", count_done(0), 0);
    check("t5 rst no done_u", count_done(1), 0);

    // Back-to-back: start is held during the DONE cycle
    inj_cyc = 5; inj_a = 4'b0101; inj_b = 4'b0100;
    launch(4'd3, 4'd3);
    watch(12);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("t6 dut%0d done1", k), first_done(k), 5);
      check($sformatf("t6 dut%0d busy@5", k), busy_o[k][5], 1'b0);
      check($sformatf("t6 dut%0d busy@6", k), busy_o[k][6], 1'b1);
      check($sformatf("t6 dut%0d hold@9", k), flags_o[k][9], 3'b001);
      check($sformatf("t6 dut%0d done@10", k), done_o[k][10], 1'b1);
      check($sformatf("t6 dut%0d flags@10", k), flags_o[k][10], 3'b100);
      check($sformatf("t6 dut%0d done_count", k), count_done(k), 2);
    end

    // Randomized operands, about a quarter of them forced equal
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
      run_one(ra, rb, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
